// File: rtl/sfifo_param.sv
// sfifo_param: parametrised synchronous FIFO with occupancy, almost/error flags and flush.
// Define SFIFO_FWFT_EN for first-word fall-through reads; default is a registered 1-cycle read.
module sfifo_param #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 2,
    parameter int AE_MARGIN = 2,
    parameter int CW        = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             wen,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ren,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             rd_ok, wr_ok;

    always_comb begin
        full         = count == CW'(DEPTH);
        empty        = count == '0;
        almost_full  = int'(count) >= DEPTH - AF_MARGIN;
        almost_empty = int'(count) <= AE_MARGIN;
        rd_ok        = ren & ~empty;
        // a pop in the same cycle frees the slot, so a full FIFO still takes the write
        wr_ok        = wen & (~full | rd_ok);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset || flush) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wptr      <= wr_ok ? wptr + AW'(1) : wptr;
            rptr      <= rd_ok ? rptr + AW'(1) : rptr;
            count     <= count + CW'(wr_ok) - CW'(rd_ok);
            overflow  <= overflow | (wen & ~wr_ok);
            underflow <= underflow | (ren & empty);
        end
    end

    always_ff @(posedge clock) begin
        if (wr_ok && !flush && !reset)
            mem[wptr] <= wdata;
    end

`ifdef SFIFO_FWFT_EN
    logic [WIDTH-1:0] last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            last <= '0;
        else if (rd_ok && !flush)
            last <= mem[rptr];
    end

    always_comb begin
        rdata  = empty ? last : mem[rptr];
        rvalid = ~empty;
    end
`else
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else if (flush) begin
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_ok;
            rdata  <= rd_ok ? mem[rptr] : rdata;
        end
    end
`endif
endmodule

// File: tb/tb_sfifo_param.sv
// tb_sfifo_param: randomized and directed checks of sfifo_param against a queue-based model.
module tb_sfifo_param;
    localparam int WIDTH = 16, DEPTH = 16, AF = 2, AE = 2, CW = $clog2(DEPTH) + 1;

    logic             clock = 1'b0, reset = 1'b1, flush = 1'b0, wen = 1'b0, ren = 1'b0;
    logic [WIDTH-1:0] wdata = '0;
    logic [WIDTH-1:0] rdata;
    logic             rvalid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [CW-1:0]    count;

    sfifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_MARGIN(AF), .AE_MARGIN(AE)) dut (
        .clock(clock), .reset(reset), .flush(flush), .wen(wen), .wdata(wdata), .ren(ren),
        .rdata(rdata), .rvalid(rvalid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_rdata = '0, m_last = '0;
    logic             m_rvalid = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
    int               n_cmp = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rdata = '0; m_last = '0; m_rvalid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    endtask

    task automatic model_step(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic f);
        bit rd_ok, wr_ok;
        rd_ok = r && q.size() > 0;
        wr_ok = w && (q.size() < DEPTH || rd_ok);
        if (f) begin
            q.delete();
            m_rvalid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            if (w && !wr_ok) m_ovf = 1'b1;
            if (r && q.size() == 0) m_udf = 1'b1;
            m_rvalid = rd_ok;
            if (rd_ok) begin
                m_rdata = q.pop_front();
                m_last  = m_rdata;
            end
            if (wr_ok) q.push_back(d);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        check("count", 32'(count), 32'(n));
        check("full", 32'(full), 32'(n == DEPTH));
        check("empty", 32'(empty), 32'(n == 0));
        check("almost_full", 32'(almost_full), 32'(n >= DEPTH - AF));
        check("almost_empty", 32'(almost_empty), 32'(n <= AE));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_udf));
`ifdef SFIFO_FWFT_EN
        check("rvalid", 32'(rvalid), 32'(n > 0));
        check("rdata", 32'(rdata), 32'(n > 0 ? q[0] : m_last));
`else
        check("rvalid", 32'(rvalid), 32'(m_rvalid));
        check("rdata", 32'(rdata), 32'(m_rdata));
`endif
    endtask

    task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic f);
        wen = w; wdata = d; ren = r; flush = f;
        @(posedge clock);
        model_step(w, d, r, f);
        #1;
        wen = 1'b0; ren = 1'b0; flush = 1'b0;
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check_all();
        // fill 1..16, then one refused write
        for (int i = 1; i <= DEPTH; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
        step(1'b1, 16'hDEAD, 1'b0, 1'b0);
        // full with simultaneous read/write
        step(1'b1, 16'hBEEF, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 16'h1234, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        // wrap-around at steady occupancy 8
        for (int i = 0; i < 8; i++) step(1'b1, WIDTH'(16'h100 + i), 1'b0, 1'b0);
        for (int i = 8; i < 48; i++) step(1'b1, WIDTH'(16'h100 + i), 1'b1, 1'b0);
        // count 5 with overflow set, then flush with a write pending
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(16'h200 + i), 1'b0, 1'b0);
        step(1'b1, 16'hBAD0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 16'hBAD1, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        // randomized phases biased toward filling or draining
        for (int i = 0; i < 1600; i++) begin
            int wp;
            wp = ((i / 60) % 2 == 0) ? 75 : 30;
            step($urandom_range(99) < wp, WIDTH'($urandom), $urandom_range(99) < 100 - wp,
                 $urandom_range(127) == 0);
        end
        for (int i = 0; i < 6; i++) step(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
        // asynchronous reset between edges
        #3 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clock);
        #1 reset = 1'b0;
        check_all();
        step(1'b1, 16'h5A5A, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
